// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - PC owner, single-outstanding imem fetch and in-order instruction FIFO
package fetch_queue_pkg;

  typedef struct packed {
    logic        valid;
    logic [63:0] order;
    logic [31:0] inst;
    logic        trap;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
  } rvfi_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        br_pred;
    logic [31:0] br_pred_info;
    rvfi_t       rvfi;
  } imem_pkt_t;

endpackage

module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int          IQ_DEPTH = 8,
  parameter logic [31:0] RESET_PC = 32'h1eceb000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  output logic [3:0]  imem_rmask,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  input  logic        deq,
  output imem_pkt_t   imem_q_data,
  output logic        iq_empty,
  output logic        iq_full
);

  localparam int          AW      = $clog2(IQ_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(IQ_DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [31:0]   r_pc;
  logic [31:0]   w_pc_nxt;
  logic [31:0]   r_addr;
  logic [31:0]   w_addr_nxt;
  logic [3:0]    r_rmask;
  logic [3:0]    w_rmask_nxt;
  logic [AW:0]   r_count;
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic          w_push;
  logic          w_pop;
  logic [AW:0]   w_count_push;
  logic [31:0]   w_pc_plus4;
  logic [31:0]   w_head_pc;

  logic [31:0]   r_instr_mem [IQ_DEPTH];
  logic [31:0]   r_pc_mem    [IQ_DEPTH];

  // A flush squashes the queue, so a coincident dequeue is not honoured.
  assign w_pop        = deq && (r_count != '0) && !flush;
  // Occupancy after this cycle if the pending response is pushed.
  assign w_count_push = r_count + (AW+1)'(1) - {{AW{1'b0}}, w_pop};
  assign w_pc_plus4   = r_pc + 32'd4;

  // Next-state, next-PC and request-port decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_addr_nxt  = r_addr;
    w_rmask_nxt = r_rmask;
    w_push      = 1'b0;
    case (r_state)
      IDLE: begin
        if (flush) begin
          w_pc_nxt = redirect_pc;
        end else if (r_count < DEPTH_C) begin
          w_addr_nxt  = r_pc;
          w_rmask_nxt = 4'hF;
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (flush) begin
          w_pc_nxt = redirect_pc;
          if (imem_resp) begin
            w_rmask_nxt = 4'h0;
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = DRAIN;
          end
        end else if (imem_resp) begin
          w_push   = 1'b1;
          w_pc_nxt = w_pc_plus4;
          if (w_count_push < DEPTH_C) begin
            w_addr_nxt = w_pc_plus4;
          end else begin
            w_rmask_nxt = 4'h0;
            w_state_nxt = IDLE;
          end
        end
      end
      DRAIN: begin
        if (flush) begin
          w_pc_nxt = redirect_pc;
          // The stale request completing on the flush cycle leaves nothing
          // outstanding, so waiting on in DRAIN would never terminate.
          if (imem_resp) begin
            w_rmask_nxt = 4'h0;
            w_state_nxt = IDLE;
          end
        end else if (imem_resp) begin
          w_addr_nxt  = r_pc;
          w_state_nxt = WAIT;
        end
      end
      default: begin
        w_rmask_nxt = 4'h0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // FSM, PC and registered request port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
      r_addr  <= 32'h0;
      r_rmask <= 4'h0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_addr  <= w_addr_nxt;
      r_rmask <= w_rmask_nxt;
    end
  end

  // FIFO pointers and occupancy; flush empties the queue in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_head  <= '0;
      r_tail  <= '0;
    end else if (flush) begin
      r_count <= '0;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + AW'(1);
      if (w_pop)  r_head <= r_head + AW'(1);
      r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end
  end

  // Entry storage; contents are only meaningful below the occupancy count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr_mem[r_tail] <= imem_rdata;
      r_pc_mem[r_tail]    <= r_pc;
    end
  end

  assign w_head_pc = r_pc_mem[r_head];

  // Head packet assembled combinationally from the stored word and PC.
  always_comb begin
    imem_q_data               = '0;
    imem_q_data.valid         = (r_count != '0);
    imem_q_data.instr         = r_instr_mem[r_head];
    imem_q_data.pc            = w_head_pc;
    imem_q_data.rvfi.pc_rdata = w_head_pc;
    imem_q_data.rvfi.pc_wdata = w_head_pc + 32'd4;
    imem_q_data.rvfi.inst     = r_instr_mem[r_head];
  end

  assign imem_addr  = r_addr;
  assign imem_rmask = r_rmask;
  assign iq_empty   = (r_count == '0);
  assign iq_full    = (r_count == DEPTH_C);

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - randomized scoreboard bench for fetch_queue
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int          DEPTH = 8;
  localparam logic [31:0] RPC   = 32'h1eceb000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_resp = 1'b0;
  logic        deq = 1'b0;
  imem_pkt_t   imem_q_data;
  logic        iq_empty;
  logic        iq_full;

  always #5 clk = ~clk;

  fetch_queue #(.IQ_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .redirect_pc (redirect_pc),
    .imem_addr   (imem_addr),
    .imem_rmask  (imem_rmask),
    .imem_rdata  (imem_rdata),
    .imem_resp   (imem_resp),
    .deq         (deq),
    .imem_q_data (imem_q_data),
    .iq_empty    (iq_empty),
    .iq_full     (iq_full)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  int          maxlat = 0;
  int          deq_pct = 0;
  int          flush_pct = 0;
  bit          force_deq = 1'b0;

  logic [31:0] model_pc = RPC;
  bit          stale = 1'b0;
  int          age = 0;
  int          lat = 0;
  bit          prev_out = 1'b0;
  bit          prev_resp = 1'b0;
  logic [3:0]  rm_pend = 4'hF;
  logic [3:0]  rm_exp = 4'h0;
  bit          addr_chk = 1'b0;
  logic [31:0] addr_exp = 32'h0;
  int          size_now = 0;

  // Memory responder and stimulus; expected packets are queued as responses are issued.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      exp_q.delete();
      model_pc  = RPC;
      stale     = 1'b0;
      prev_out  = 1'b0;
      prev_resp = 1'b0;
      rm_pend   = 4'hF;
      rm_exp    = 4'h0;
      addr_chk  = 1'b0;
      size_now  = 0;
      age       = 0;
      lat       = 0;
      imem_resp = 1'b0;
      flush     = 1'b0;
      deq       = 1'b0;
    end else begin
      bit   out_now;
      bit   new_req;
      int   deq_eff;
      exp_t e;
      rm_exp   = rm_pend;
      size_now = exp_q.size();
      out_now  = (imem_rmask == 4'hF);
      new_req  = out_now && (!prev_out || prev_resp);
      addr_chk = new_req;
      addr_exp = model_pc;
      if (new_req) begin
        lat = $urandom_range(0, maxlat);
        age = 0;
      end
      imem_resp = out_now && (age == lat);
      if (out_now && !imem_resp) age++;
      imem_rdata  = imem_resp ? word_of(imem_addr) : $urandom;
      flush       = ($urandom_range(0, 99) < flush_pct);
      redirect_pc = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      deq         = force_deq || ($urandom_range(0, 99) < deq_pct);
      deq_eff     = (deq && size_now > 0 && !flush) ? 1 : 0;
      if (flush) begin
        exp_q.delete();
        model_pc = redirect_pc;
        stale    = out_now && !imem_resp;
        rm_pend  = (out_now && !imem_resp) ? 4'hF : 4'h0;
      end else if (out_now && imem_resp) begin
        if (stale) begin
          stale   = 1'b0;
          rm_pend = 4'hF;
        end else begin
          e.pc    = model_pc;
          e.instr = word_of(model_pc);
          exp_q.push_back(e);
          model_pc = model_pc + 32'd4;
          rm_pend  = (size_now + 1 - deq_eff < DEPTH) ? 4'hF : 4'h0;
        end
      end else if (out_now) begin
        rm_pend = 4'hF;
      end else begin
        rm_pend = (size_now < DEPTH) ? 4'hF : 4'h0;
      end
      prev_out  = out_now;
      prev_resp = imem_resp;
    end
  end

  // Monitor: compares DUT outputs with the scoreboard and pops on dequeue.
  always @(negedge clk) begin
    if (rst_n) begin
      check("rmask", {60'h0, imem_rmask}, {60'h0, rm_exp});
      if (addr_chk) check("issue_addr", {32'h0, imem_addr}, {32'h0, addr_exp});
      check("iq_empty", {63'h0, iq_empty}, {63'h0, size_now == 0});
      check("iq_full", {63'h0, iq_full}, {63'h0, size_now == DEPTH});
      check("head_valid", {63'h0, imem_q_data.valid}, {63'h0, size_now > 0});
      if (size_now > 0 && !flush) begin
        check("head_pc", {32'h0, imem_q_data.pc}, {32'h0, exp_q[0].pc});
        check("head_instr", {32'h0, imem_q_data.instr}, {32'h0, exp_q[0].instr});
        if (deq) begin
          check("rvfi_pc_wdata", {32'h0, imem_q_data.rvfi.pc_wdata}, {32'h0, exp_q[0].pc + 32'd4});
          check("rvfi_inst", {32'h0, imem_q_data.rvfi.inst}, {32'h0, exp_q[0].instr});
          check("br_pred", {63'h0, imem_q_data.br_pred}, 64'h0);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic check_reset_outputs();
    check("rst_rmask", {60'h0, imem_rmask}, 64'h0);
    check("rst_addr", {32'h0, imem_addr}, 64'h0);
    check("rst_valid", {63'h0, imem_q_data.valid}, 64'h0);
    check("rst_empty", {63'h0, iq_empty}, 64'h1);
    check("rst_full", {63'h0, iq_full}, 64'h0);
  endtask

  task automatic wait_req(input string name, input logic [31:0] exp_addr);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      @(negedge clk);
      #2;
      if (imem_rmask == 4'hF) found = 1'b1;
    end
    check({name, "_seen"}, {63'h0, found}, 64'h1);
    check({name, "_addr"}, {32'h0, imem_addr}, {32'h0, exp_addr});
  endtask

  initial begin
    int cfg [4][3];
    cfg = '{'{0, 50, 5}, '{3, 30, 10}, '{2, 90, 3}, '{1, 70, 20}};

    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs();
    #1 rst_n = 1'b1;

    // Single-cycle memory with no consumer fills the queue and stops.
    repeat (20) @(negedge clk);
    #2;
    check("fill_full", {63'h0, iq_full}, 64'h1);
    check("fill_rmask", {60'h0, imem_rmask}, 64'h0);
    check("fill_head_pc", {32'h0, imem_q_data.pc}, {32'h0, RPC});

    // One dequeue reopens a slot and fetch resumes where it stopped.
    force_deq = 1'b1;
    @(posedge clk);
    #3 force_deq = 1'b0;
    wait_req("refetch", RPC + 32'h20);
    repeat (4) @(negedge clk);
    #2;
    check("refill_full", {63'h0, iq_full}, 64'h1);

    for (int p = 0; p < 4; p++) begin
      maxlat    = cfg[p][0];
      deq_pct   = cfg[p][1];
      flush_pct = cfg[p][2];
      repeat (1500) @(negedge clk);
    end

    // Asynchronous reset while a request is outstanding.
    flush_pct = 0;
    maxlat    = 3;
    deq_pct   = 60;
    begin
      bit in_wait;
      in_wait = 1'b0;
      for (int i = 0; i < 50 && !in_wait; i++) begin
        @(posedge clk);
        #3;
        if (imem_rmask == 4'hF && !imem_resp) in_wait = 1'b1;
      end
      check("wait_seen", {63'h0, in_wait}, 64'h1);
    end
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    wait_req("post_reset", RPC);
    repeat (300) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
